// File: rtl/button_event_queue.sv
// ---------------------------------------------------------------------------
// button_event_queue
//
// Purpose:
//   Each raw button level from the matrix scanner passes through a two-flop
//   synchroniser and a per-button debouncer. Every net change of debounced
//   state raises a per-button pending bit. Pending bits drain into a small
//   show-ahead event FIFO, lowest button index first, one per cycle. Under
//   backpressure an event waits in its pending bit and is never dropped.
//   Two flips that happen before a push cancel each other, so the stream
//   reports net state only.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   synchronous active-high reset
//   rawStates    in   [ROWS*COLS] raw levels, bit index = row*COLS+col
//   stableStates out  [ROWS*COLS] debounced levels
//   eventValid   out  queue head holds an event
//   eventKey     out  [KEY_W] button index of the head event
//   eventPressed out  head event level (1 = press, 0 = release)
//   eventReady   in   consumer pops the head when eventValid is also high
// ---------------------------------------------------------------------------
module button_event_queue #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    localparam int NB             = ROWS * COLS,
    localparam int KEY_W          = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NB-1:0]    rawStates,
    output logic [NB-1:0]    stableStates,
    output logic             eventValid,
    output logic [KEY_W-1:0] eventKey,
    output logic             eventPressed,
    input  logic             eventReady
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_FW-1:0] DEPTH_C  = CNT_FW'(FIFO_DEPTH);

    // Synchroniser, debounce and pending state
    logic [NB-1:0]    sync1_q;
    logic [NB-1:0]    sync2_q;
    logic [NB-1:0]    stable_q;
    logic [NB-1:0]    stable_d;
    logic [NB-1:0]    pending_q;
    logic [NB-1:0]    pending_d;
    logic [NB-1:0]    toggle_s;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];

    // Event queue state
    logic [KEY_W-1:0]  key_mem_q [FIFO_DEPTH];
    logic              lvl_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_FW-1:0] count_q;
    logic [CNT_FW-1:0] count_d;
    logic              valid_q;
    logic              valid_d;

    // Push / pop controls
    logic             push_s;
    logic             pop_s;
    logic [KEY_W-1:0] push_key_s;
    logic             push_lvl_s;
    logic [NB-1:0]    push_sel_s;

    // Per-button debounce: count consecutive disagreeing samples, flip on the last one
    always_comb begin
        stable_d = stable_q;
        toggle_s = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    cnt_d[i]    = '0;
                    toggle_s[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Lowest-index pending button wins; descending scan leaves the lowest set index last
    always_comb begin
        push_key_s = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                push_key_s = KEY_W'(i);
            end else begin
                push_key_s = push_key_s;
            end
        end
    end

    // Queue control; the full test uses the pre-edge count, so no push-through-pop bypass
    always_comb begin
        push_s     = (|pending_q) && (count_q < DEPTH_C);
        pop_s      = valid_q && eventReady;
        // Pushed level is the registered stable level; a same-cycle flip re-arms pending
        push_lvl_s = stable_q[push_key_s];
        if (push_s) begin
            push_sel_s = NB'(1) << push_key_s;
        end else begin
            push_sel_s = '0;
        end
        pending_d = pending_q ^ toggle_s ^ push_sel_s;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_FW'(1);
            2'b01:   count_d = count_q - CNT_FW'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
    end

    // All state registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                key_mem_q[j] <= '0;
                lvl_mem_q[j] <= 1'b0;
            end
        end else begin
            sync1_q   <= rawStates;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            // Writes never land on the head slot while it holds a live event
            if (push_s) begin
                key_mem_q[wr_ptr_q] <= push_key_s;
                lvl_mem_q[wr_ptr_q] <= push_lvl_s;
            end else begin
                key_mem_q[wr_ptr_q] <= key_mem_q[wr_ptr_q];
                lvl_mem_q[wr_ptr_q] <= lvl_mem_q[wr_ptr_q];
            end
        end
    end

    assign stableStates = stable_q;
    assign eventValid   = valid_q;
    assign eventKey     = key_mem_q[rd_ptr_q];
    assign eventPressed = lvl_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_button_event_queue.sv
// ---------------------------------------------------------------------------
// Testbench for button_event_queue (ROWS=COLS=4, DEBOUNCE_CYCLES=4,
// FIFO_DEPTH=4). Stimulus pushes expected events into a scoreboard queue; a
// monitor pops and compares on every handshake at the falling edge. Directed
// timing checks are made 1 time unit after rising edges.
// ---------------------------------------------------------------------------
module tb_button_event_queue;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] rawStates;
    logic [15:0] stableStates;
    logic        eventValid;
    logic [3:0]  eventKey;
    logic        eventPressed;
    logic        eventReady;

    typedef struct packed {
        logic [3:0] key;
        logic       pressed;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    button_event_queue #(
        .ROWS(4), .COLS(4), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)
    ) dut (
        .CLK(CLK), .RST(RST), .rawStates(rawStates), .stableStates(stableStates),
        .eventValid(eventValid), .eventKey(eventKey), .eventPressed(eventPressed),
        .eventReady(eventReady)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input logic p);
        ev_t e;
        e.key     = 4'(k);
        e.pressed = p;
        sb.push_back(e);
    endtask

    task automatic expect_mask(input logic [15:0] m, input logic p);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) expect_ev(i, p);
        end
    endtask

    // Advance n rising edges, then settle 1 unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Monitor: every accepted event must match the scoreboard head
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge CLK);
            if (RST === 1'b0 && eventValid === 1'b1 && eventReady === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got key %0d pressed %0d, expected none",
                             eventKey, eventPressed);
                end else begin
                    e = sb.pop_front();
                    check("event_key", 32'(eventKey), 32'(e.key));
                    check("event_level", 32'(eventPressed), 32'(e.pressed));
                end
            end
        end
    end

    initial begin : stimulus
        // 1. Reset with all raw bits high, then normal timing
        RST        = 1'b1;
        rawStates  = 16'hFFFF;
        eventReady = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_stable", 32'(stableStates), 32'h0);
        check("rst_valid", 32'(eventValid), 32'h0);
        check("rst_key", 32'(eventKey), 32'h0);
        check("rst_pressed", 32'(eventPressed), 32'h0);
        RST = 1'b0;
        expect_mask(16'hFFFF, 1'b1);
        step(5);
        check("rst_follow_before", 32'(stableStates), 32'h0);
        step(1);
        check("rst_follow_flip", 32'(stableStates), 32'hFFFF);
        step(25);
        rawStates = 16'h0000;
        expect_mask(16'hFFFF, 1'b0);
        step(30);
        check("all_released", 32'(stableStates), 32'h0);

        // 2. Single press and release of button 5
        rawStates[5] = 1'b1;
        expect_ev(5, 1'b1);
        step(5);
        check("press_stable_e5", 32'(stableStates[5]), 32'h0);
        step(1);
        check("press_stable_e6", 32'(stableStates[5]), 32'h1);
        check("press_valid_e6", 32'(eventValid), 32'h0);
        step(1);
        check("press_valid_e7", 32'(eventValid), 32'h1);
        check("press_key_e7", 32'(eventKey), 32'd5);
        check("press_level_e7", 32'(eventPressed), 32'h1);
        step(1);
        check("press_valid_e8", 32'(eventValid), 32'h0);
        step(4);
        rawStates[5] = 1'b0;
        expect_ev(5, 1'b0);
        step(5);
        check("rel_stable_e5", 32'(stableStates[5]), 32'h1);
        step(1);
        check("rel_stable_e6", 32'(stableStates[5]), 32'h0);
        step(1);
        check("rel_valid_e7", 32'(eventValid), 32'h1);
        check("rel_key_e7", 32'(eventKey), 32'd5);
        check("rel_level_e7", 32'(eventPressed), 32'h0);
        step(1);
        check("rel_valid_e8", 32'(eventValid), 32'h0);
        step(4);

        // 3. Glitch on button 3 shorter than the debounce window
        rawStates[3] = 1'b1;
        step(3);
        rawStates[3] = 1'b0;
        step(15);
        check("glitch_stable", 32'(stableStates), 32'h0);
        check("glitch_valid", 32'(eventValid), 32'h0);

        // 4. Simultaneous presses 0, 7, 15
        rawStates = 16'h8081;
        expect_mask(16'h8081, 1'b1);
        step(7);
        check("sim_key0", 32'(eventKey), 32'd0);
        check("sim_valid0", 32'(eventValid), 32'h1);
        step(1);
        check("sim_key7", 32'(eventKey), 32'd7);
        step(1);
        check("sim_key15", 32'(eventKey), 32'd15);
        step(1);
        check("sim_valid_end", 32'(eventValid), 32'h0);
        rawStates = 16'h0000;
        expect_mask(16'h8081, 1'b0);
        step(20);

        // 5. Backpressure: six presses, four slots
        eventReady = 1'b0;
        rawStates  = 16'h0556;
        expect_mask(16'h0556, 1'b1);
        step(20);
        check("bp_valid", 32'(eventValid), 32'h1);
        check("bp_head", 32'(eventKey), 32'd1);
        step(5);
        check("bp_head_stable", 32'(eventKey), 32'd1);
        check("bp_head_level", 32'(eventPressed), 32'h1);
        eventReady = 1'b1;
        step(15);
        check("bp_drained", sb.size(), 32'd0);

        // 6a. Press and release of 9 while the queue is full cancels out
        eventReady = 1'b0;
        rawStates  = 16'h0000;
        expect_mask(16'h0556, 1'b0);
        step(12);
        rawStates[9] = 1'b1;
        step(10);
        check("cancel_stable_hi", 32'(stableStates[9]), 32'h1);
        rawStates[9] = 1'b0;
        step(10);
        check("cancel_stable_lo", 32'(stableStates[9]), 32'h0);
        eventReady = 1'b1;
        step(20);
        check("cancel_drained", sb.size(), 32'd0);
        check("cancel_valid", 32'(eventValid), 32'h0);

        // 6b. Reset with three queued events discards them
        eventReady = 1'b0;
        rawStates  = 16'h3800;
        expect_mask(16'h3800, 1'b1);
        step(12);
        check("mid_valid", 32'(eventValid), 32'h1);
        check("mid_head", 32'(eventKey), 32'd11);
        RST       = 1'b1;
        rawStates = 16'h0000;
        sb.delete();
        step(1);
        check("mid_rst_valid", 32'(eventValid), 32'h0);
        check("mid_rst_stable", 32'(stableStates), 32'h0);
        RST        = 1'b0;
        eventReady = 1'b1;
        step(20);
        check("mid_post_valid", 32'(eventValid), 32'h0);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
